// File: rtl/button_debounce_if.sv
// Button conditioning bus: raw levels in, debounced levels and edge pulses out.
interface button_debounce_if #(
  parameter int unsigned width_p = 3
);
  logic [width_p-1:0] button_async_unsafe_i;
  logic [width_p-1:0] button_o;
  logic [width_p-1:0] press_o;
  logic [width_p-1:0] release_o;

  modport master (
    output button_async_unsafe_i,
    input  button_o,
    input  press_o,
    input  release_o
  );

  modport slave (
    input  button_async_unsafe_i,
    output button_o,
    output press_o,
    output release_o
  );
endinterface

// File: rtl/button_debounce.sv
// Per-bit synchronizer plus stability-counter debouncer with press/release pulses.
module button_debounce #(
  parameter int unsigned width_p         = 3,
  parameter int unsigned sync_stages_p   = 2,
  parameter int unsigned stable_cycles_p = 120000
) (
  input  logic               clk_12mhz_i,
  input  logic               reset_n_async_unsafe_i,
  button_debounce_if.slave   bus
);

  localparam int unsigned CNT_W =
    ($clog2(stable_cycles_p + 1) < 1) ? 1 : $clog2(stable_cycles_p + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(stable_cycles_p - 1);

  logic [width_p-1:0] r_sync [sync_stages_p];
  logic [CNT_W-1:0]   r_cnt  [width_p];
  logic [width_p-1:0] r_button;
  logic [width_p-1:0] r_press;
  logic [width_p-1:0] r_release;
  logic [width_p-1:0] w_sync;

  assign w_sync = r_sync[sync_stages_p-1];

  always_ff @(posedge clk_12mhz_i or negedge reset_n_async_unsafe_i) begin
    if (!reset_n_async_unsafe_i) begin
      for (int unsigned j = 0; j < sync_stages_p; j++) r_sync[j] <= '0;
      for (int unsigned i = 0; i < width_p; i++) r_cnt[i] <= '0;
      r_button  <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_sync[0] <= bus.button_async_unsafe_i;
      for (int unsigned j = 1; j < sync_stages_p; j++) r_sync[j] <= r_sync[j-1];
      for (int unsigned i = 0; i < width_p; i++) begin
        if (w_sync[i] == r_button[i]) begin
          r_cnt[i]     <= '0;
          r_press[i]   <= 1'b0;
          r_release[i] <= 1'b0;
        end else if (r_cnt[i] == CNT_LAST) begin
          // Flip only after the full run of disagreeing cycles; any agreement above restarts it.
          r_button[i]  <= w_sync[i];
          r_cnt[i]     <= '0;
          r_press[i]   <= w_sync[i];
          r_release[i] <= ~w_sync[i];
        end else begin
          r_cnt[i]     <= r_cnt[i] + 1'b1;
          r_press[i]   <= 1'b0;
          r_release[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.button_o  = r_button;
  assign bus.press_o   = r_press;
  assign bus.release_o = r_release;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with stable_cycles_p=4, sync_stages_p=2, width_p=3.
module tb_button_debounce;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  button_debounce_if #(.width_p(3)) bif ();

  button_debounce #(
    .width_p(3),
    .sync_stages_p(2),
    .stable_cycles_p(4)
  ) dut (
    .clk_12mhz_i(clk),
    .reset_n_async_unsafe_i(rst_n),
    .bus(bif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] b, input logic [2:0] p,
                           input logic [2:0] r);
    check({tag, ".btn"}, {29'd0, bif.button_o}, {29'd0, b});
    check({tag, ".prs"}, {29'd0, bif.press_o}, {29'd0, p});
    check({tag, ".rel"}, {29'd0, bif.release_o}, {29'd0, r});
  endtask

  task automatic watch(input string tag, input int n, input logic [2:0] b,
                       input logic [2:0] p, input logic [2:0] r);
    for (int i = 0; i < n; i++) begin
      step();
      check_out(tag, b, p, r);
    end
  endtask

  task automatic do_reset(input logic [2:0] in_v);
    bif.button_async_unsafe_i = in_v;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bif.button_async_unsafe_i = 3'b111;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst_async", 3'b000, 3'b000, 3'b000);
    watch("rst_hold", 3, 3'b000, 3'b000, 3'b000);
    rst_n = 1'b1;
    watch("rst_lat", 5, 3'b000, 3'b000, 3'b000);
    watch("rst_rise", 1, 3'b111, 3'b111, 3'b000);
    watch("rst_after", 2, 3'b111, 3'b000, 3'b000);

    do_reset(3'b000);
    bif.button_async_unsafe_i = 3'b001;
    watch("b0_lat", 5, 3'b000, 3'b000, 3'b000);
    watch("b0_rise", 1, 3'b001, 3'b001, 3'b000);
    watch("b0_hold", 10, 3'b001, 3'b000, 3'b000);
    bif.button_async_unsafe_i = 3'b000;
    watch("b0_rlat", 5, 3'b001, 3'b000, 3'b000);
    watch("b0_fall", 1, 3'b000, 3'b000, 3'b001);
    watch("b0_idle", 2, 3'b000, 3'b000, 3'b000);

    for (int ph = 0; ph < 20; ph++) begin
      bif.button_async_unsafe_i = (ph % 2 == 0) ? 3'b010 : 3'b000;
      watch("bnc", 2, 3'b000, 3'b000, 3'b000);
    end
    bif.button_async_unsafe_i = 3'b010;
    watch("bnc_lat", 5, 3'b000, 3'b000, 3'b000);
    watch("bnc_rise", 1, 3'b010, 3'b010, 3'b000);
    watch("bnc_hold", 2, 3'b010, 3'b000, 3'b000);

    do_reset(3'b000);
    bif.button_async_unsafe_i = 3'b100;
    watch("gl_pre", 3, 3'b000, 3'b000, 3'b000);
    bif.button_async_unsafe_i = 3'b000;
    watch("gl_dip", 1, 3'b000, 3'b000, 3'b000);
    bif.button_async_unsafe_i = 3'b100;
    watch("gl_lat", 5, 3'b000, 3'b000, 3'b000);
    watch("gl_rise", 1, 3'b100, 3'b100, 3'b000);
    watch("gl_hold", 2, 3'b100, 3'b000, 3'b000);

    do_reset(3'b000);
    for (int c = 0; c < 12; c++) begin
      bif.button_async_unsafe_i = {1'b0, ((c / 2) % 2 == 0), 1'b1};
      step();
      check_out("ind", (c >= 5) ? 3'b001 : 3'b000, (c == 5) ? 3'b001 : 3'b000, 3'b000);
    end

    do_reset(3'b000);
    bif.button_async_unsafe_i = 3'b100;
    watch("ar_pre", 5, 3'b000, 3'b000, 3'b000);
    watch("ar_prise", 1, 3'b100, 3'b100, 3'b000);
    watch("ar_phold", 1, 3'b100, 3'b000, 3'b000);
    bif.button_async_unsafe_i = 3'b101;
    watch("ar_cnt", 4, 3'b100, 3'b000, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("ar_imm", 3'b000, 3'b000, 3'b000);
    watch("ar_held", 2, 3'b000, 3'b000, 3'b000);
    rst_n = 1'b1;
    watch("ar_lat", 5, 3'b000, 3'b000, 3'b000);
    watch("ar_rise", 1, 3'b101, 3'b101, 3'b000);
    watch("ar_hold", 2, 3'b101, 3'b000, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
